spi_ram_arbiter: RTL and testbench
==================================

# spi_ram_arbiter

Two-requester arbiter for the shared single-port RAM behind the SPI slave. Requester A (the SPI slave's rx path) and requester B (a local host port) each present 10-bit RAM command words. The block grants the RAM round-robin and keeps each address/data command pair atomic, so one requester cannot corrupt the other's latched address. It routes the RAM read-data return to whichever requester issued the read.

## Interface
- `ADDR_W`, 8: payload width; command word is `ADDR_W+2` bits, with opcode in the top 2 bits.
- `TO_CYCLES`, 16: stall-timeout limit, in cycles. Used only when `SPI_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `a_din`  in  10  requester A command word
- `a_valid`  in  1  A command present
- `a_ready`  out  1  A command accepted this cycle when high with `a_valid`
- `a_rdata`  out  8  read data returned to A
- `a_rvalid`  out  1  one-cycle pulse qualifying `a_rdata`
- `b_din`, `b_valid`, `b_ready`, `b_rdata`, `b_rvalid`: same as A, for requester B
- `ram_din`  out  10  command word to RAM
- `ram_rx_valid`  out  1  one-cycle pulse qualifying `ram_din`
- `ram_dout`  in  8  RAM read data
- `ram_tx_valid`  in  1  RAM read data valid
- `busy`  out  1  high in any state other than IDLE
- `err`  out  1  one-cycle timeout pulse
- `err_src`  out  1  requester that timed out: 0 = A, 1 = B

## Operation
- Opcodes in `din[9:8]`:
  - 00 = WR_ADDR
  - 01 = WR_DATA
  - 10 = RD_ADDR
  - 11 = RD_DATA
- States: IDLE, LOCK_A, LOCK_B, WAIT_RD. Register `owner` records the requester holding the lock.
- IDLE:
  - One valid requester: that requester wins.
  - Both valid: the requester not granted last wins.
  - `last` resets to B, so A wins the first tie.
  - Only the winner's ready is high.
- Accepted command, by opcode:
  - WR_ADDR or RD_ADDR: go to LOCK_owner.
  - WR_DATA: go to IDLE.
  - RD_DATA: go to WAIT_RD.
  - Every accepted command is forwarded to the RAM and updates `last`.
- LOCK_x:
  - Only x's ready may be high; the other requester waits.
  - A further address command keeps the lock and is forwarded.
  - WR_DATA releases the lock (go to IDLE).
  - RD_DATA goes to WAIT_RD.
- WAIT_RD:
  - All readies are low.
  - On `ram_tx_valid`, capture `ram_dout` into the owner's rdata, pulse that requester's rvalid, and go to IDLE.
- `ram_tx_valid` outside WAIT_RD is ignored.
- A requester's rdata holds its last value until that requester's next read return.

## Timing
- Readies are combinational from state, `last` and the valids; they are forced low while `rst_n` is low.
- Accept on cycle N produces `ram_din` and `ram_rx_valid` in cycle N+1, registered. At most one RAM command per cycle.
- `ram_tx_valid` in cycle M produces the rdata/rvalid pulse in cycle M+1. The block returns to IDLE in M+1, so a new accept is possible in M+1.
- Back-to-back WR_DATA from different requesters: one accept per cycle, alternating under contention.
- Reset values:
  - state IDLE, `last` = B, `owner` = A
  - `ram_din` = 0, `ram_rx_valid` = 0
  - both rdata = 0, both rvalid = 0
  - `busy` = 0, `err` = 0, `err_src` = 0, timeout counter = 0
- Asserting `rst_n` mid-transaction immediately abandons the lock or pending read. A `ram_tx_valid` arriving after reset is ignored.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter runs in LOCK_x and WAIT_RD; it clears on every accept or read return and on entry to IDLE.
  - When the counter reaches `TO_CYCLES`, the block goes to IDLE, pulses `err` for one cycle, and sets `err_src` = owner. No rvalid pulse is issued.
- Undefined:
  - No counter; `err` and `err_src` are tied to 0.
  - LOCK and WAIT_RD wait indefinitely.

## Structure
- Shared package `spi_ram_pkg` holds:
  - opcode localparams (`OP_WR_ADDR`, `OP_WR_DATA`, `OP_RD_ADDR`, `OP_RD_DATA`)
  - the state enum typedef
  - the command-width constant
- One sub-module, `rr_pick2`:
  - combinational 2-way round-robin picker
  - inputs: two valids and `last`; outputs: one-hot grant
- State machine, routing and timeout counter live in the top module.

## Test plan
- Reset, then A issues 00_0A and then 01_5C, with B idle:
  - `ram_rx_valid` pulses carry 00_0A, then 01_5C, one cycle after each accept.
  - `busy` is high between the two commands.
- A issues 10_0A, then 11_xx; RAM returns `ram_tx_valid` with 5C two cycles later:
  - `a_rdata` = 5C with a one-cycle `a_rvalid` pulse.
  - `b_rvalid` stays 0.
- A is locked after 00_0A and B presents 01_33 continuously:
  - `b_ready` stays low until A's 01_11 is accepted.
  - The RAM then sees 01_11 followed by 01_33, never interleaved.
- A and B both present WR_DATA every cycle starting from IDLE after reset:
  - Grants go A, B, A, B.
  - `ram_rx_valid` is high every cycle.
- With the macro defined and `TO_CYCLES`=16, A sends 10_0A and then goes silent:
  - `err` pulses exactly 16 cycles after the lock with `err_src` = 0.
  - The block is back in IDLE and B is then granted.
- In WAIT_RD, `rst_n` is pulsed low and then `ram_tx_valid` arrives:
  - All outputs read 0 during reset.
  - No rvalid pulse occurs after reset.

Source files
------------

// File: rtl/spi_ram_pkg.sv
// Shared opcodes, state encoding and widths for the SPI RAM arbiter.
// The optional stall timeout is built only when SPI_ARB_TIMEOUT_EN is defined.
package spi_ram_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int CMD_W      = DEF_ADDR_W + 2;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCK_A  = 2'd1,
        ST_LOCK_B  = 2'd2,
        ST_WAIT_RD = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    // Address opcodes (WR_ADDR, RD_ADDR) take or keep the lock.
    function automatic logic is_addr_op(input logic [1:0] op);
        return (op == OP_WR_ADDR) || (op == OP_RD_ADDR);
    endfunction

endpackage

// File: rtl/spi_ram_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the requester that
// was not granted last wins. Grant is one-hot (bit 0 = A, bit 1 = B) or zero.
module rr_pick2 (
    input  logic       valid_a_i,
    input  logic       valid_b_i,
    input  logic       last_b_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        if (valid_a_i && valid_b_i) begin
            grant_o = last_b_i ? 2'b01 : 2'b10;
        end else if (valid_a_i) begin
            grant_o = 2'b01;
        end else if (valid_b_i) begin
            grant_o = 2'b10;
        end
    end

endmodule

// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter for the single-port RAM behind the SPI slave; keeps
// address/data pairs atomic and routes read returns. SPI_ARB_TIMEOUT_EN adds a stall timeout.
module spi_ram_arbiter
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W    = CMD_W - 2,
    parameter int TO_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W+1:0] a_din,
    input  logic              a_valid,
    output logic              a_ready,
    output logic [ADDR_W-1:0] a_rdata,
    output logic              a_rvalid,
    input  logic [ADDR_W+1:0] b_din,
    input  logic              b_valid,
    output logic              b_ready,
    output logic [ADDR_W-1:0] b_rdata,
    output logic              b_rvalid,
    output logic [ADDR_W+1:0] ram_din,
    output logic              ram_rx_valid,
    input  logic [ADDR_W-1:0] ram_dout,
    input  logic              ram_tx_valid,
    output logic              busy,
    output logic              err,
    output logic              err_src
);

    arb_state_e        state_q;
    req_e              last_q;
    req_e              owner_q;
    logic [ADDR_W+1:0] ram_din_q;
    logic              ram_rx_valid_q;
    logic [ADDR_W-1:0] a_rdata_q;
    logic [ADDR_W-1:0] b_rdata_q;
    logic              a_rvalid_q;
    logic              b_rvalid_q;

    logic [1:0]        pick;
    logic              a_rdy;
    logic              b_rdy;
    logic              acc_a;
    logic              acc_b;
    logic              any_acc;
    req_e              acc_req;
    logic [ADDR_W+1:0] acc_cmd;
    logic [1:0]        acc_op;
    logic              rd_return;
    logic              timeout;

    rr_pick2 u_pick (
        .valid_a_i (a_valid),
        .valid_b_i (b_valid),
        .last_b_i  (last_q == REQ_B),
        .grant_o   (pick)
    );

    // Only the lock holder may talk while locked; nobody while a read is outstanding.
    always_comb begin
        a_rdy = 1'b0;
        b_rdy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                a_rdy = pick[0];
                b_rdy = pick[1];
            end
            ST_LOCK_A: a_rdy = 1'b1;
            ST_LOCK_B: b_rdy = 1'b1;
            default: begin
                a_rdy = 1'b0;
                b_rdy = 1'b0;
            end
        endcase
    end

    assign a_ready   = a_rdy & rst_n;
    assign b_ready   = b_rdy & rst_n;
    assign acc_a     = a_valid & a_ready;
    assign acc_b     = b_valid & b_ready;
    assign any_acc   = acc_a | acc_b;
    assign acc_req   = acc_b ? REQ_B : REQ_A;
    assign acc_cmd   = acc_b ? b_din : a_din;
    assign acc_op    = acc_cmd[ADDR_W+1:ADDR_W];
    assign rd_return = (state_q == ST_WAIT_RD) && ram_tx_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_q         <= REQ_B;
            owner_q        <= REQ_A;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            a_rdata_q      <= '0;
            b_rdata_q      <= '0;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
        end else begin
            ram_rx_valid_q <= any_acc;
            a_rvalid_q     <= 1'b0;
            b_rvalid_q     <= 1'b0;
            if (any_acc) begin
                ram_din_q <= acc_cmd;
                last_q    <= acc_req;
                owner_q   <= acc_req;
                if (is_addr_op(acc_op)) begin
                    state_q <= (acc_req == REQ_B) ? ST_LOCK_B : ST_LOCK_A;
                end else if (acc_op == OP_RD_DATA) begin
                    state_q <= ST_WAIT_RD;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else if (rd_return) begin
                state_q <= ST_IDLE;
                if (owner_q == REQ_B) begin
                    b_rdata_q  <= ram_dout;
                    b_rvalid_q <= 1'b1;
                end else begin
                    a_rdata_q  <= ram_dout;
                    a_rvalid_q <= 1'b1;
                end
            end else if (timeout) begin
                state_q <= ST_IDLE;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_CYCLES + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;
    req_e            err_src_q;

    // Fires on the cycle the count would reach TO_CYCLES with no progress.
    assign timeout = (state_q != ST_IDLE) && !any_acc && !rd_return
                     && (to_cnt_q == TO_W'(TO_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q  <= '0;
            err_q     <= 1'b0;
            err_src_q <= REQ_A;
        end else begin
            err_q <= timeout;
            if (timeout) begin
                err_src_q <= owner_q;
            end
            if ((state_q == ST_IDLE) || any_acc || rd_return || timeout) begin
                to_cnt_q <= '0;
            end else begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
        end
    end

    assign err     = err_q;
    assign err_src = err_src_q;
`else
    logic unused_to_cycles;
    assign unused_to_cycles = (TO_CYCLES > 0);
    assign timeout          = 1'b0;
    assign err              = 1'b0;
    assign err_src          = 1'b0;
`endif

    assign ram_din      = ram_din_q;
    assign ram_rx_valid = ram_rx_valid_q;
    assign a_rdata      = a_rdata_q;
    assign a_rvalid     = a_rvalid_q;
    assign b_rdata      = b_rdata_q;
    assign b_rvalid     = b_rvalid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Randomised scoreboard bench for spi_ram_arbiter: two transaction-level requesters,
// a behavioural RAM and an ideal-memory model; the timeout case runs when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_ram_arbiter;

    localparam int CYCLES = 3000;
    localparam int DRAIN  = 120;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] a_din = '0;
    logic       a_valid = 1'b0;
    logic [9:0] b_din = '0;
    logic       b_valid = 1'b0;
    logic [7:0] ram_dout = '0;
    logic       ram_tx_valid = 1'b0;
    logic       a_ready, a_rvalid, b_ready, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic [9:0] ram_din;
    logic       ram_rx_valid, busy, err, err_src;

    always #5 clk = ~clk;

    spi_ram_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a_din        (a_din),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rdata      (a_rdata),
        .a_rvalid     (a_rvalid),
        .b_din        (b_din),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rdata      (b_rdata),
        .b_rvalid     (b_rvalid),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid),
        .busy         (busy),
        .err          (err),
        .err_src      (err_src)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard queues: RAM command stream and per-requester read returns.
    logic [9:0] exp_ram_q[$];
    logic [7:0] exp_a_q[$];
    logic [7:0] exp_b_q[$];
    logic [7:0] a_hold = '0;
    logic [7:0] b_hold = '0;

    // Behavioural RAM driven by what the DUT actually forwards.
    logic [7:0] ram_mem[256];
    logic [7:0] ram_addr = '0;
    // Ideal memory updated from each requester's intended transactions.
    logic [7:0] ideal_mem[256];

    // Monitor: compares DUT outputs against the scoreboard queues.
    initial begin
        logic [9:0] e;
        logic [7:0] r;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            if (ram_rx_valid) begin
                if (exp_ram_q.size() == 0) begin
                    check("ram_rx_spurious", 32'(ram_rx_valid), 32'd0);
                end else begin
                    e = exp_ram_q.pop_front();
                    check("ram_cmd", 32'(ram_din), 32'(e));
                end
                case (ram_din[9:8])
                    2'b00, 2'b10: ram_addr = ram_din[7:0];
                    2'b01:        ram_mem[ram_addr] = ram_din[7:0];
                    default:      ;
                endcase
            end
            if (a_rvalid) begin
                if (exp_a_q.size() == 0) check("a_rvalid_spurious", 32'(a_rvalid), 32'd0);
                else begin
                    r = exp_a_q.pop_front();
                    check("a_rdata", 32'(a_rdata), 32'(r));
                end
                a_hold = a_rdata;
            end else begin
                check("a_rdata_hold", 32'(a_rdata), 32'(a_hold));
            end
            if (b_rvalid) begin
                if (exp_b_q.size() == 0) check("b_rvalid_spurious", 32'(b_rvalid), 32'd0);
                else begin
                    r = exp_b_q.pop_front();
                    check("b_rdata", 32'(b_rdata), 32'(r));
                end
                b_hold = b_rdata;
            end else begin
                check("b_rdata_hold", 32'(b_rdata), 32'(b_hold));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got t=%0t required <200000", $time);
        $fatal(1);
    end

    // Model state: lock holder (-1 none, 0 A, 1 B), pending read, round-robin history.
    int         holder = -1;
    bit         waiting = 0;
    int         rd_owner = 0;
    logic [7:0] rd_addr = '0;
    int         last = 1;
    int         rd_delay = 0;
    int         wait_age = 0;
    bit         rst_done = 0;

    // Requester drivers: each runs write (addr,data) or read (addr) transactions.
    bit         acc[2];
    bit         active[2];
    int         step[2];
    int         gap[2];
    bit         is_rd[2];
    logic [7:0] t_addr[2];
    logic [7:0] t_data[2];

    initial begin
        bit         stop;
        bit         v;
        bit         ea, eb;
        int         r;
        logic [9:0] d;
        logic [9:0] cmd;

        for (int i = 0; i < 256; i++) begin
            ram_mem[i]   = 8'($urandom);
            ideal_mem[i] = ram_mem[i];
        end
        for (int i = 0; i < 2; i++) begin
            acc[i] = 0; active[i] = 0; step[i] = 0; gap[i] = 0;
        end

        // Readies must stay low in reset even with both requesters valid.
        a_valid = 1'b1; b_valid = 1'b1; a_din = 10'h100; b_din = 10'h100;
        #12;
        check("reset_outputs", 32'({a_ready, b_ready, ram_rx_valid, ram_din, a_rdata, a_rvalid,
                                    b_rdata, b_rvalid, busy, err, err_src}), 32'd0);
        a_valid = 1'b0; b_valid = 1'b0; a_din = '0; b_din = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < CYCLES + DRAIN; cyc++) begin
            @(posedge clk);
            #1;
            stop = (cyc >= CYCLES);
            for (int q = 0; q < 2; q++) begin
                if (acc[q]) begin
                    acc[q] = 0;
                    step[q]++;
                    if (step[q] == 2) active[q] = 0;
                    else gap[q] = $urandom_range(0, 3);
                end
                if (!active[q] && !stop && $urandom_range(0, 99) < 60) begin
                    active[q] = 1;
                    step[q]   = 0;
                    gap[q]    = 0;
                    is_rd[q]  = ($urandom_range(0, 2) == 0);
                    t_addr[q] = 8'($urandom_range(0, 15));
                    t_data[q] = 8'($urandom);
                end
                v = 1'b0;
                d = '0;
                if (active[q]) begin
                    if (gap[q] > 0) gap[q]--;
                    else begin
                        v = 1'b1;
                        d = {is_rd[q], step[q] == 1, (step[q] == 0) ? t_addr[q] : t_data[q]};
                    end
                end
                if (q == 0) begin a_valid = v; a_din = d; end
                else        begin b_valid = v; b_din = d; end
            end

            ram_tx_valid = 1'b0;
            if (!rst_done && waiting && wait_age >= 1 && cyc > 300) begin
                // Abandon an outstanding read with an asynchronous reset pulse.
                rst_n = 1'b0;
                #2;
                check("midrun_reset_outputs", 32'({a_ready, b_ready, ram_rx_valid, ram_din, a_rdata,
                      a_rvalid, b_rdata, b_rvalid, busy, err, err_src}), 32'd0);
                rst_n = 1'b1;
                holder = -1; waiting = 0; last = 1; a_hold = '0; b_hold = '0;
                ram_tx_valid = 1'b1;
                ram_dout     = 8'hA5;
                rst_done     = 1;
            end else if (waiting) begin
                if (rd_delay == 0) begin
                    ram_tx_valid = 1'b1;
                    ram_dout     = ram_mem[ram_addr];
                end else begin
                    rd_delay--;
                end
                wait_age++;
            end else if ($urandom_range(0, 9) == 0) begin
                ram_tx_valid = 1'b1;
                ram_dout     = 8'($urandom);
            end

            @(negedge clk);
            check("busy", 32'(busy), 32'(waiting || holder != -1));
            check("err_idle", 32'(err), 32'd0);
            ea = 0; eb = 0;
            if (waiting) begin
                ea = 0; eb = 0;
            end else if (holder == 0) begin
                ea = a_valid;
            end else if (holder == 1) begin
                eb = b_valid;
            end else if (a_valid && b_valid) begin
                if (last == 1) ea = 1; else eb = 1;
            end else begin
                ea = a_valid; eb = b_valid;
            end
            check("a_accept", 32'(a_ready && a_valid), 32'(ea));
            check("b_accept", 32'(b_ready && b_valid), 32'(eb));

            if (waiting && ram_tx_valid) begin
                if (rd_owner == 0) exp_a_q.push_back(ideal_mem[rd_addr]);
                else               exp_b_q.push_back(ideal_mem[rd_addr]);
                waiting = 0;
            end else if (ea || eb) begin
                r   = ea ? 0 : 1;
                cmd = (r == 0) ? a_din : b_din;
                exp_ram_q.push_back(cmd);
                last   = r;
                acc[r] = 1;
                case (cmd[9:8])
                    2'b00, 2'b10: holder = r;
                    2'b01: begin
                        ideal_mem[t_addr[r]] = t_data[r];
                        holder = -1;
                    end
                    default: begin
                        holder   = -1;
                        waiting  = 1;
                        rd_owner = r;
                        rd_addr  = t_addr[r];
                        rd_delay = $urandom_range(1, 4);
                        wait_age = 0;
                    end
                endcase
            end
        end

        @(posedge clk);
        #1;
        a_valid = 1'b0; b_valid = 1'b0; ram_tx_valid = 1'b0;
        @(negedge clk);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_ram_q", 32'(exp_ram_q.size()), 32'd0);
        check("drain_a_q", 32'(exp_a_q.size()), 32'd0);
        check("drain_b_q", 32'(exp_b_q.size()), 32'd0);
        check("reset_was_hit", 32'(rst_done), 32'd1);

`ifdef SPI_ARB_TIMEOUT_EN
        // A locks with RD_ADDR then goes silent; B waits behind the lock.
        @(posedge clk);
        #1;
        a_din = 10'h20A; a_valid = 1'b1;
        @(negedge clk);
        check("to_a_accept", 32'(a_ready), 32'd1);
        exp_ram_q.push_back(10'h20A);
        @(posedge clk);
        #1;
        a_valid = 1'b0; b_din = 10'h133; b_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("to_err", 32'(err), 32'(k == 17));
            check("to_b_ready", 32'(b_ready), 32'(k == 17));
            if (k == 17) begin
                check("to_err_src", 32'(err_src), 32'd0);
                exp_ram_q.push_back(10'h133);
            end
            @(posedge clk);
            #1;
            if (k == 17) b_valid = 1'b0;
        end
        @(negedge clk);
        check("to_ram_q", 32'(exp_ram_q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
